// File: rtl/pedestrian_scheduler_if.sv
// Bundle between the collision logic (hit/enable) and the sprite mapper
// (positions and state) around the pedestrian scheduler.
interface pedestrian_scheduler_if;
  logic        enable;
  logic [3:0]  hit;
  logic [3:0]  ped_active;
  logic [3:0]  ped_hit;
  logic [43:0] ped_x;
  logic [43:0] ped_y;
  logic [10:0] ped_s;
  logic [7:0]  hit_count;
  logic        spawn_drop;

  modport master (
    output enable, hit,
    input  ped_active, ped_hit, ped_x, ped_y, ped_s, hit_count, spawn_drop
  );

  modport slave (
    input  enable, hit,
    output ped_active, ped_hit, ped_x, ped_y, ped_s, hit_count, spawn_drop
  );
endinterface

// File: rtl/pedestrian_scheduler.sv
// Four-slot pedestrian spawner/mover: periodic spawns into the lowest idle
// slot, LFSR-chosen lane and direction, hit freeze with saturating hit tally.
module pedestrian_scheduler #(
  parameter int         SPAWN_PERIOD = 60,
  parameter int         HIT_HOLD     = 30,
  parameter int         X_STEP       = 3,
  parameter int         X_MAX        = 639,
  parameter int         PED_SIZE     = 8,
  parameter int         LANE_Y0      = 120,
  parameter int         LANE_Y1      = 200,
  parameter int         LANE_Y2      = 280,
  parameter int         LANE_Y3      = 360,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  pedestrian_scheduler_if.slave  bus
);

  localparam int CW = $clog2(SPAWN_PERIOD);
  localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_HIT  = 2'd2
  } state_t;

  // Fibonacci feedback for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic lfsr_fb(input logic [7:0] v);
    return v[7] ^ v[5] ^ v[4] ^ v[3];
  endfunction

  function automatic logic [3:0] lowest_one(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [10:0] lane_y(input logic [1:0] sel);
    logic [10:0] y;
    case (sel)
      2'd0:    y = 11'(LANE_Y0);
      2'd1:    y = 11'(LANE_Y1);
      2'd2:    y = 11'(LANE_Y2);
      2'd3:    y = 11'(LANE_Y3);
      default: y = 11'(LANE_Y0);
    endcase
    return y;
  endfunction

  state_t          r_state [4];
  logic [10:0]     r_x     [4];
  logic [10:0]     r_y     [4];
  logic            r_dir   [4];
  logic [HW-1:0]   r_hold  [4];
  logic [3:0]      r_active;
  logic [3:0]      r_hit;
  logic [CW-1:0]   r_spawn_cnt;
  logic [7:0]      r_lfsr;
  logic [7:0]      r_hit_count;
  logic            r_spawn_drop;

  logic [3:0]      w_idle;
  logic [3:0]      w_walk;
  logic [3:0]      w_spawn_sel;
  logic [3:0]      w_new_hit;
  logic            w_spawn_now;
  logic [8:0]      w_hit_sum;
  logic [7:0]      w_hit_count_nxt;

  // Spawn target from the pre-edge state, and the saturating hit tally.
  always_comb begin
    w_idle = 4'd0;
    w_walk = 4'd0;
    for (int i = 0; i < 4; i++) begin
      w_idle[i] = (r_state[i] == S_IDLE);
      w_walk[i] = (r_state[i] == S_WALK);
    end
    w_spawn_now = (r_spawn_cnt == CW'(SPAWN_PERIOD - 1));
    w_spawn_sel = lowest_one(w_idle);
    w_new_hit   = w_walk & bus.hit;
    w_hit_sum   = {1'b0, r_hit_count} + 9'(popcount4(w_new_hit));
    if (w_hit_sum > 9'd255) begin
      w_hit_count_nxt = 8'd255;
    end else begin
      w_hit_count_nxt = w_hit_sum[7:0];
    end
  end

  // Slot state machines, spawn counter, LFSR and registered status outputs.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i] <= S_IDLE;
        r_x[i]     <= 11'd0;
        r_y[i]     <= 11'd0;
        r_dir[i]   <= 1'b0;
        r_hold[i]  <= HW'(0);
      end
      r_active     <= 4'd0;
      r_hit        <= 4'd0;
      r_spawn_cnt  <= CW'(0);
      r_lfsr       <= LFSR_SEED;
      r_hit_count  <= 8'd0;
      r_spawn_drop <= 1'b0;
    end else if (bus.enable) begin
      r_lfsr       <= {r_lfsr[6:0], lfsr_fb(r_lfsr)};
      r_spawn_cnt  <= w_spawn_now ? CW'(0) : r_spawn_cnt + CW'(1);
      r_spawn_drop <= w_spawn_now && (w_idle == 4'd0);
      r_hit_count  <= w_hit_count_nxt;
      for (int i = 0; i < 4; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_spawn_now && w_spawn_sel[i]) begin
              r_state[i]  <= S_WALK;
              r_active[i] <= 1'b1;
              r_dir[i]    <= r_lfsr[2];
              r_x[i]      <= r_lfsr[2] ? 11'(X_MAX) : 11'd0;
              r_y[i]      <= lane_y(r_lfsr[1:0]);
            end
          end
          // Hit takes priority over leaving the road on the same edge.
          S_WALK: begin
            if (bus.hit[i]) begin
              r_state[i] <= S_HIT;
              r_hit[i]   <= 1'b1;
              r_hold[i]  <= HW'(HIT_HOLD - 1);
            end else if (!r_dir[i]) begin
              if (({1'b0, r_x[i]} + 12'(X_STEP)) > 12'(X_MAX)) begin
                r_state[i]  <= S_IDLE;
                r_active[i] <= 1'b0;
              end else begin
                r_x[i] <= r_x[i] + 11'(X_STEP);
              end
            end else begin
              if (r_x[i] < 11'(X_STEP)) begin
                r_state[i]  <= S_IDLE;
                r_active[i] <= 1'b0;
              end else begin
                r_x[i] <= r_x[i] - 11'(X_STEP);
              end
            end
          end
          S_HIT: begin
            if (r_hold[i] == HW'(0)) begin
              r_state[i]  <= S_IDLE;
              r_active[i] <= 1'b0;
              r_hit[i]    <= 1'b0;
            end else begin
              r_hold[i] <= r_hold[i] - HW'(1);
            end
          end
          default: begin
            r_state[i]  <= S_IDLE;
            r_active[i] <= 1'b0;
            r_hit[i]    <= 1'b0;
          end
        endcase
      end
    end else begin
      r_spawn_drop <= 1'b0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign bus.ped_x[11*g +: 11] = r_x[g];
    assign bus.ped_y[11*g +: 11] = r_y[g];
  end

  assign bus.ped_active = r_active;
  assign bus.ped_hit    = r_hit;
  assign bus.ped_s      = 11'(PED_SIZE);
  assign bus.hit_count  = r_hit_count;
  assign bus.spawn_drop = r_spawn_drop;

endmodule

// File: tb/tb_pedestrian_scheduler.sv
// Randomized bench for pedestrian_scheduler against a frame-level model of
// slot occupancy, motion, hit holds and spawn scheduling.
module tb_pedestrian_scheduler;

  localparam int         SP   = 40;
  localparam int         HH   = 12;
  localparam int         XS   = 3;
  localparam int         XM   = 639;
  localparam int         PS   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  pedestrian_scheduler_if bus ();

  pedestrian_scheduler #(
    .SPAWN_PERIOD(SP), .HIT_HOLD(HH), .X_STEP(XS), .X_MAX(XM), .PED_SIZE(PS),
    .LANE_Y0(120), .LANE_Y1(200), .LANE_Y2(280), .LANE_Y3(360), .LFSR_SEED(SEED)
  ) dut (
    .frame_clk(clk),
    .Reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 = free, 1 = walking, 2 = frozen after a hit.
  int         m_st    [4];
  int         m_x     [4];
  int         m_y     [4];
  int         m_dir   [4];
  int         m_hold  [4];
  int         m_frames;
  int         m_hits;
  int         m_drop;
  logic [7:0] m_lfsr;
  int         lanes   [4] = '{120, 200, 280, 360};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic en, input logic [3:0] h, input logic r);
    int pre [4];
    int nh;
    int sel;
    bit attempt;
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_hold[i] = 0;
      end
      m_frames = 0; m_hits = 0; m_drop = 0; m_lfsr = SEED;
    end else if (en) begin
      attempt = ((m_frames % SP) == SP - 1);
      m_frames++;
      pre = m_st;
      nh  = 0;
      for (int i = 0; i < 4; i++) begin
        if (pre[i] == 1) begin
          if (h[i]) begin
            m_st[i] = 2; m_hold[i] = HH; nh++;
          end else if (m_dir[i] == 0) begin
            if (m_x[i] + XS > XM) m_st[i] = 0;
            else m_x[i] += XS;
          end else begin
            if (m_x[i] < XS) m_st[i] = 0;
            else m_x[i] -= XS;
          end
        end else if (pre[i] == 2) begin
          m_hold[i]--;
          if (m_hold[i] == 0) m_st[i] = 0;
        end
      end
      m_drop = 0;
      if (attempt) begin
        sel = -1;
        for (int i = 3; i >= 0; i--) if (pre[i] == 0) sel = i;
        if (sel < 0) m_drop = 1;
        else begin
          m_st[sel]  = 1;
          m_dir[sel] = int'(m_lfsr[2]);
          m_x[sel]   = m_lfsr[2] ? XM : 0;
          m_y[sel]   = lanes[m_lfsr[1:0]];
        end
      end
      m_hits = (m_hits + nh > 255) ? 255 : m_hits + nh;
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end else begin
      m_drop = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] ea;
    logic [3:0] eh;
    for (int i = 0; i < 4; i++) begin
      ea[i] = (m_st[i] != 0);
      eh[i] = (m_st[i] == 2);
    end
    check_eq("ped_active", 64'(bus.ped_active), 64'(ea));
    check_eq("ped_hit", 64'(bus.ped_hit), 64'(eh));
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ped_x%0d", i), 64'(bus.ped_x[11*i +: 11]), 64'(m_x[i]));
      check_eq($sformatf("ped_y%0d", i), 64'(bus.ped_y[11*i +: 11]), 64'(m_y[i]));
    end
    check_eq("ped_s", 64'(bus.ped_s), 64'(PS));
    check_eq("hit_count", 64'(bus.hit_count), 64'(m_hits));
    check_eq("spawn_drop", 64'(bus.spawn_drop), 64'(m_drop));
  endtask

  task automatic step(input logic en, input logic [3:0] h, input logic rst_in);
    bus.enable = en;
    bus.hit    = h;
    rst        = rst_in;
    @(posedge clk);
    model_update(en, h, rst_in);
    #1;
    compare_all();
  endtask

  function automatic logic [3:0] rand_hits(input int one_in);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, one_in - 1) == 0);
    return v;
  endfunction

  initial begin
    logic any_hit;
    n_vec = 0;
    n_miss = 0;
    bus.enable = 1'b0;
    bus.hit = 4'd0;
    rst = 1'b1;

    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'hF, 1'b1);

    // Sparse hits with occasional stalls; one stall window holds hit[1] high.
    for (int k = 0; k < 4000; k++) begin
      if (k >= 1500 && k < 1510) step(1'b0, 4'b0010, 1'b0);
      else step(($urandom_range(0, 9) != 0), rand_hits(64), 1'b0);
    end

    // Dense hits to drive hit_count into saturation.
    for (int k = 0; k < 20000; k++) begin
      if (m_hits == 255) break;
      step(1'b1, rand_hits(8), 1'b0);
    end
    for (int k = 0; k < 300; k++) step(1'b1, rand_hits(4), 1'b0);
    check_eq("hit_count_sat", 64'(bus.hit_count), 64'd255);

    // Reset while a slot is frozen in its hit hold.
    any_hit = 1'b0;
    for (int k = 0; k < 1000 && !any_hit; k++) begin
      step(1'b1, rand_hits(8), 1'b0);
      any_hit = (m_st[0] == 2) || (m_st[1] == 2) || (m_st[2] == 2) || (m_st[3] == 2);
    end
    check_eq("hold_reached", 64'(any_hit), 64'd1);
    step(1'b1, 4'hF, 1'b1);
    check_eq("rst_active", 64'(bus.ped_active), 64'd0);
    check_eq("rst_count", 64'(bus.hit_count), 64'd0);
    for (int k = 0; k < 200; k++) step(1'b1, rand_hits(32), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
